// File: rtl/psys_route_pkg.sv
// Shared constants, types and helpers for the data-route packing path.
package psys_route_pkg;

  localparam int DEF_IN_W  = 128;
  localparam int DEF_RATIO = 12;
  localparam int MAX_RATIO = 64;

  typedef logic [31:0] perf_cnt_t;

  localparam perf_cnt_t PERF_CNT_MAX = '1;

  // Callers slice the low RATIO bits of the result.
  function automatic logic [MAX_RATIO-1:0] lane_onehot(input logic [5:0] idx);
    return MAX_RATIO'(1) << idx;
  endfunction

  function automatic perf_cnt_t perf_sat_inc(input perf_cnt_t cnt);
    return (cnt == PERF_CNT_MAX) ? cnt : cnt + perf_cnt_t'(1);
  endfunction

endpackage

// File: rtl/axis_out_slice.sv
// Output register of the upsizer: loads a packed word, holds it under
// backpressure and drops valid after the downstream handshake.
module axis_out_slice
  import psys_route_pkg::*;
#(
  parameter  int IN_W  = DEF_IN_W,
  parameter  int RATIO = DEF_RATIO,
  localparam int OUT_W = IN_W * RATIO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [OUT_W-1:0] tdata_i,
  input  logic [RATIO-1:0] tkeep_i,
  input  logic             tlast_i,
  input  logic [RATIO-1:0] tlast_lane_i,
  input  logic             m_axis_tready_i,
  output logic [OUT_W-1:0] m_axis_tdata_o,
  output logic             m_axis_tvalid_o,
  output logic [RATIO-1:0] m_axis_tkeep_o,
  output logic             m_axis_tlast_o,
  output logic [RATIO-1:0] m_axis_tlast_lane_o,
  output logic             free_o
);

  logic [OUT_W-1:0] tdata_q, tdata_d;
  logic [RATIO-1:0] tkeep_q, tkeep_d;
  logic [RATIO-1:0] lane_q, lane_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;

  assign free_o = ~valid_q | m_axis_tready_i;

  // load_i is only raised while free_o is high, so a held word never changes.
  always_comb begin
    tdata_d = tdata_q;
    tkeep_d = tkeep_q;
    lane_d  = lane_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (load_i) begin
      tdata_d = tdata_i;
      tkeep_d = tkeep_i;
      lane_d  = tlast_lane_i;
      last_d  = tlast_i;
      valid_d = 1'b1;
    end else if (m_axis_tready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdata_q <= '0;
      tkeep_q <= '0;
      lane_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      tdata_q <= tdata_d;
      tkeep_q <= tkeep_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign m_axis_tdata_o      = tdata_q;
  assign m_axis_tkeep_o      = tkeep_q;
  assign m_axis_tlast_o      = last_q;
  assign m_axis_tlast_lane_o = lane_q;
  assign m_axis_tvalid_o     = valid_q;

endmodule

// File: rtl/axis_upsizer_param.sv
// AXI-Stream width upsizer packing RATIO IN_W beats into one output word.
// Define AXIS_UPSIZER_PERF_CNT_EN to add saturating performance counters.
module axis_upsizer_param
  import psys_route_pkg::*;
#(
  parameter  int IN_W  = DEF_IN_W,
  parameter  int RATIO = DEF_RATIO,
  localparam int OUT_W = IN_W * RATIO,
  localparam int IDX_W = $clog2(RATIO)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [RATIO-1:0] m_axis_tkeep,
  output logic             m_axis_tlast,
`ifdef AXIS_UPSIZER_PERF_CNT_EN
  output logic [31:0]      perf_word_cnt,
  output logic [31:0]      perf_partial_cnt,
  output logic [31:0]      perf_stall_cnt,
`endif
  output logic [RATIO-1:0] m_axis_tlast_lane
);

  logic [OUT_W-1:0]     acc_q, acc_d, merged_data, load_data;
  logic [RATIO-1:0]     keep_q, keep_d, merged_keep, load_keep;
  logic [RATIO-1:0]     tll_q, tll_d, merged_tll, load_tll;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 pend_q, pend_d;
  logic                 pend_last_q, pend_last_d;
  logic                 accept, complete, out_free, load, load_last;
  logic [MAX_RATIO-1:0] oh_full;
  logic [RATIO-1:0]     lane_oh;

  assign s_axis_tready = ~pend_q;
  assign accept        = s_axis_tvalid & ~pend_q;
  assign complete      = accept & ((idx_q == IDX_W'(RATIO - 1)) | s_axis_tlast);

  assign oh_full = lane_onehot(6'(idx_q));
  assign lane_oh = oh_full[RATIO-1:0];

  always_comb begin
    merged_data = acc_q;
    for (int k = 0; k < RATIO; k++) begin
      if (lane_oh[k]) merged_data[k*IN_W +: IN_W] = s_axis_tdata;
    end
  end

  assign merged_keep = keep_q | lane_oh;
  assign merged_tll  = tll_q | (s_axis_tlast ? lane_oh : '0);

  // A pending word always drains before new beats are accepted, since
  // s_axis_tready is low while it waits.
  always_comb begin
    acc_d       = acc_q;
    keep_d      = keep_q;
    tll_d       = tll_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    pend_last_d = pend_last_q;
    load        = 1'b0;
    load_data   = merged_data;
    load_keep   = merged_keep;
    load_tll    = merged_tll;
    load_last   = s_axis_tlast;
    if (pend_q) begin
      load_data = acc_q;
      load_keep = keep_q;
      load_tll  = tll_q;
      load_last = pend_last_q;
      if (out_free) begin
        load        = 1'b1;
        acc_d       = '0;
        keep_d      = '0;
        tll_d       = '0;
        pend_d      = 1'b0;
        pend_last_d = 1'b0;
      end
    end else if (complete) begin
      idx_d = '0;
      if (out_free) begin
        load   = 1'b1;
        acc_d  = '0;
        keep_d = '0;
        tll_d  = '0;
      end else begin
        acc_d       = merged_data;
        keep_d      = merged_keep;
        tll_d       = merged_tll;
        pend_d      = 1'b1;
        pend_last_d = s_axis_tlast;
      end
    end else if (accept) begin
      acc_d  = merged_data;
      keep_d = merged_keep;
      tll_d  = merged_tll;
      idx_d  = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      keep_q      <= '0;
      tll_q       <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      keep_q      <= keep_d;
      tll_q       <= tll_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
    end
  end

  axis_out_slice #(
    .IN_W  (IN_W),
    .RATIO (RATIO)
  ) u_out_slice (
    .clk                 (clk),
    .rst                 (rst),
    .load_i              (load),
    .tdata_i             (load_data),
    .tkeep_i             (load_keep),
    .tlast_i             (load_last),
    .tlast_lane_i        (load_tll),
    .m_axis_tready_i     (m_axis_tready),
    .m_axis_tdata_o      (m_axis_tdata),
    .m_axis_tvalid_o     (m_axis_tvalid),
    .m_axis_tkeep_o      (m_axis_tkeep),
    .m_axis_tlast_o      (m_axis_tlast),
    .m_axis_tlast_lane_o (m_axis_tlast_lane),
    .free_o              (out_free)
  );

`ifdef AXIS_UPSIZER_PERF_CNT_EN
  perf_cnt_t word_cnt_q, partial_cnt_q, stall_cnt_q;
  logic      out_hs;

  assign out_hs = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt_q    <= '0;
      partial_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      if (out_hs) word_cnt_q <= perf_sat_inc(word_cnt_q);
      if (out_hs && !(&m_axis_tkeep)) partial_cnt_q <= perf_sat_inc(partial_cnt_q);
      if (s_axis_tvalid && !s_axis_tready) stall_cnt_q <= perf_sat_inc(stall_cnt_q);
    end
  end

  assign perf_word_cnt    = word_cnt_q;
  assign perf_partial_cnt = partial_cnt_q;
  assign perf_stall_cnt   = stall_cnt_q;
`endif

endmodule
